// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back / write-allocate data cache.
// Hits complete in the request cycle with no stall. A miss first writes back a
// dirty victim, then fetches the block. On return to IDLE the request is
// re-evaluated as a hit.
module data_cache #(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           proc_read,
    input  logic                           proc_write,
    input  logic [29:0]                    proc_addr,
    input  logic [31:0]                    proc_wdata,
    output logic [31:0]                    proc_rdata,
    output logic                           proc_stall,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [27:0]                    mem_addr,
    output logic [32*WORDS_PER_BLOCK-1:0]  mem_wdata,
    input  logic [32*WORDS_PER_BLOCK-1:0]  mem_rdata,
    input  logic                           mem_ready
);

    localparam int IW     = $clog2(NUM_BLOCKS);
    localparam int TW     = 28 - IW;
    localparam int LINE_W = 32 * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
    logic [TW-1:0]           tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0]       data_q [NUM_BLOCKS];

    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [27:0]             mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

    logic [IW-1:0]           idx;
    logic [TW-1:0]           tag;
    logic [1:0]              off;
    logic                    req;
    logic                    hit;
    logic [LINE_W-1:0]       cur_line;
    logic [31:0]             rd_word;
    logic                    line_we;
    logic                    tag_we;
    logic [LINE_W-1:0]       line_data_d;

    assign idx      = proc_addr[IW+1:2];
    assign tag      = proc_addr[29:IW+2];
    assign off      = proc_addr[1:0];
    assign req      = proc_read | proc_write;
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_word  = cur_line[{off, 5'b00000} +: 32];

    // Hits are answered combinationally; anything else outstanding stalls the pipe.
    assign proc_stall = req && !((state_q == IDLE) && hit);
    assign proc_rdata = (req && (state_q == IDLE) && hit) ? rd_word : 32'd0;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state, line-update and memory-request computation.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        line_data_d = cur_line;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read+write is a write.
                        if (proc_write) begin
                            line_we = 1'b1;
                            line_data_d[{off, 5'b00000} +: 32] = proc_wdata;
                            dirty_d[idx] = 1'b1;
                        end
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = WRITEBACK;
                        mem_addr_d  = {tag_q[idx], idx};
                        mem_wdata_d = cur_line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_addr_d = proc_addr[29:2];
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_d    = ALLOCATE;
                    mem_addr_d = proc_addr[29:2];
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_d      = IDLE;
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    line_data_d  = mem_rdata;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_read_d  = (state_d == ALLOCATE);
        mem_write_d = (state_d == WRITEBACK);
    end

    // FSM state, line status bits and registered memory strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Data-path storage: line arrays and memory address/data holding registers.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_data_d;
        end
        if (tag_we) begin
            tag_q[idx] <= tag;
        end
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized scoreboard bench for data_cache against a
// word-level memory model plus a per-index residency model.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    data_cache #(.NUM_BLOCKS(8), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        int          stall;
    } exp_t;

    localparam int NW = 128;          // modelled words (32 blocks)
    logic [31:0] bmem [NW];           // physical backing memory
    logic [31:0] arch [NW];           // architectural (program-visible) values
    bit          mvalid [8];
    bit          mdirty [8];
    int          mtag   [8];
    exp_t        sb [$];

    int checks = 0;
    int passed = 0;
    int lat = 1;
    int cur_blk = 0;
    int exp_wb_blk = 0;
    bit mon_en = 1'b0;
    bit completed = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] arch_block(input int b);
        logic [127:0] r;
        r = '0;
        if (b >= 0 && b < NW/4)
            for (int k = 0; k < 4; k++) r[32*k +: 32] = arch[b*4+k];
        return r;
    endfunction

    // Memory responder: answers after `lat` active cycles, random mem_ready when idle.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_read || mem_write) begin
                chk("mem_exclusive", mem_read && mem_write, 0);
                cnt++;
                if (mem_write) begin
                    chk("wb_addr", mem_addr, exp_wb_blk);
                    chk("wb_data", mem_wdata, arch_block(exp_wb_blk));
                end else begin
                    chk("alloc_addr", mem_addr, cur_blk);
                end
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (int'(mem_addr) < NW/4) begin
                        for (int k = 0; k < 4; k++) begin
                            if (mem_write) bmem[int'(mem_addr)*4+k] = mem_wdata[32*k +: 32];
                            else           mem_rdata[32*k +: 32] = bmem[int'(mem_addr)*4+k];
                        end
                    end
                end
            end else begin
                cnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: counts stall cycles and pops the scoreboard when a request completes.
    initial begin
        int   sc;
        exp_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                sc = 0;
            end else if (proc_read || proc_write) begin
                if (proc_stall) begin
                    sc++;
                end else if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_completion: addr %0h with empty scoreboard", proc_addr);
                    completed = 1'b1;
                end else begin
                    e = sb.pop_front();
                    chk("stall_cycles", sc, e.stall);
                    if (!e.wr) chk("rdata", proc_rdata, e.rdata);
                    sc = 0;
                    completed = 1'b1;
                end
            end else begin
                chk("idle_stall", proc_stall, 0);
                chk("idle_rdata", proc_rdata, 0);
            end
        end
    end

    // Issue one request: predict its result from the models, then wait for completion.
    task automatic issue(input logic [29:0] a, input bit wr, input bit rd_too,
                         input logic [31:0] wd, input int l);
        exp_t e;
        int   blk, idx, tg, c;
        blk = int'(a) / 4;
        idx = blk % 8;
        tg  = blk / 8;
        e.wr    = wr;
        e.rdata = arch[int'(a)];
        if (mvalid[idx] && mtag[idx] == tg) begin
            e.stall = 0;
        end else begin
            e.stall = (mvalid[idx] && mdirty[idx]) ? 2*l + 1 : l + 1;
            exp_wb_blk  = mtag[idx]*8 + idx;
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            mtag[idx]   = tg;
        end
        if (wr) begin
            arch[int'(a)] = wd;
            mdirty[idx]   = 1'b1;
        end
        sb.push_back(e);
        #2;
        lat        = l;
        cur_blk    = blk;
        proc_addr  = a;
        proc_write = wr;
        proc_read  = !wr || rd_too;
        proc_wdata = wd;
        completed  = 1'b0;
        c = 0;
        while (!completed && c < 300) begin
            @(posedge clk);
            c++;
        end
        if (!completed) begin
            $display("FAIL request_timeout: addr %0h still stalled after %0d cycles", a, c);
            $fatal(1);
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            #2;
            proc_read  = 1'b0;
            proc_write = 1'b0;
            repeat (n) @(posedge clk);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        for (int w = 0; w < NW; w++) begin
            bmem[w] = 32'(w - 15);
            arch[w] = 32'(w - 15);
        end
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = 0;
        end

        #3;
        chk("reset_stall", proc_stall, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_rdata", proc_rdata, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;

        // Directed sequence: fill, hit, write hit, dirty eviction, clean write miss.
        issue(30'h10, 1'b0, 1'b0, 32'h0, 3);
        issue(30'h11, 1'b0, 1'b0, 32'h0, 2);
        issue(30'h12, 1'b1, 1'b0, 32'hDEADBEEF, 2);
        issue(30'h12, 1'b0, 1'b0, 32'h0, 2);
        issue(30'h30, 1'b0, 1'b0, 32'h0, 2);
        issue(30'h50, 1'b1, 1'b0, 32'h12345678, 4);
        issue(30'h50, 1'b0, 1'b0, 32'h0, 1);
        issue(30'h53, 1'b0, 1'b1, 32'hCAFEF00D, 1);
        issue(30'h53, 1'b0, 1'b0, 32'h0, 1);
        idle(1);

        // Reset in the middle of an allocate aborts it.
        mon_en = 1'b0;
        #2;
        lat       = 50;
        cur_blk   = 25;
        proc_addr = 30'h64;
        proc_read = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("alloc_before_reset", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_mem_read", mem_read, 0);
        chk("reset_mem_write_low", mem_write, 0);
        proc_read = 1'b0;
        #1;
        chk("reset_no_req_stall", proc_stall, 0);
        chk("reset_no_req_rdata", proc_rdata, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        for (int w = 0; w < NW; w++) arch[w] = bmem[w];
        @(posedge clk);
        mon_en = 1'b1;
        issue(30'h64, 1'b0, 1'b0, 32'h0, 2);

        // Randomized traffic over 32 blocks sharing 8 lines.
        for (int n = 0; n < 200; n++) begin
            logic [29:0] a;
            int          kind;
            a    = 30'($urandom_range(0, NW-1));
            kind = $urandom_range(0, 3);
            issue(a, kind >= 2, kind == 3, $urandom, $urandom_range(1, 4));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
